// File: rtl/led_scan_capture.sv
// Purpose : decode a multiplexed 4-digit active-low 7-segment scan back into a 16-bit frame value.
// Latency : frame_valid rises SETTLE_CYCLES+1 clk after the last synced segment change in the an0 slot (+2 for synchronizers).
// Backpres: none; a passive observer. Outputs are pulses/levels and must be consumed when presented.
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   an3..an0              anode strobes, active low, asynchronous (2-flop synchronized)
//   a..g                  segment lines, active low, asynchronous (2-flop synchronized)
//   value                 last complete frame, [15:12]=an3 digit ... [3:0]=an0 digit
//   frame_valid           1-cycle pulse when value updates
//   seg_err               1-cycle pulse: sampled segment pattern is not a hex glyph
//   seq_err               1-cycle pulse: anode order violated or overlapping anodes
//   active                level: scan activity seen within the last TIMEOUT_CYCLES
module led_scan_capture #(
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        an3,
    input  logic        an2,
    input  logic        an1,
    input  logic        an0,
    input  logic        a,
    input  logic        b,
    input  logic        c,
    input  logic        d,
    input  logic        e,
    input  logic        f,
    input  logic        g,
    output logic [15:0] value,
    output logic        frame_valid,
    output logic        seg_err,
    output logic        seq_err,
    output logic        active
);

    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam int IW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX     = CW'(SETTLE_CYCLES);
    localparam logic [IW-1:0] IDLE_MAX    = IW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_WAIT_OFF} state_t;

    // Returns {ok, nibble}; pattern is {a..g} active low with a as MSB.
    function automatic logic [4:0] seg_decode(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            7'h01:   r = {1'b1, 4'h0};
            7'h4F:   r = {1'b1, 4'h1};
            7'h12:   r = {1'b1, 4'h2};
            7'h06:   r = {1'b1, 4'h3};
            7'h4C:   r = {1'b1, 4'h4};
            7'h24:   r = {1'b1, 4'h5};
            7'h20:   r = {1'b1, 4'h6};
            7'h0F:   r = {1'b1, 4'h7};
            7'h00:   r = {1'b1, 4'h8};
            7'h04:   r = {1'b1, 4'h9};
            7'h08:   r = {1'b1, 4'hA};
            7'h60:   r = {1'b1, 4'hB};
            7'h31:   r = {1'b1, 4'hC};
            7'h42:   r = {1'b1, 4'hD};
            7'h30:   r = {1'b1, 4'hE};
            7'h38:   r = {1'b1, 4'hF};
            default: r = 5'b0_0000;
        endcase
        return r;
    endfunction

    // ---------------- input synchronizers (reset to "all dark") ----------------
    logic [10:0] raw;
    logic [10:0] sync1_q, sync2_q;
    assign raw = {an3, an2, an1, an0, a, b, c, d, e, f, g};

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    logic [3:0] low;
    logic [6:0] seg_s;
    logic       any_low, one_low;
    logic [1:0] low_idx;
    assign low     = ~sync2_q[10:7];
    assign seg_s   = sync2_q[6:0];
    assign any_low = |low;
    assign one_low = any_low && ((low & (low - 4'd1)) == 4'd0);

    always_comb begin
        low_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (low[i]) low_idx = 2'(i);
        end
    end

    // ---------------- state ----------------
    state_t         state_q, state_d;
    logic [1:0]     expect_q, expect_d;
    logic [1:0]     cur_q, cur_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [6:0]     seg_prev_q, seg_prev_d;
    logic [15:0]    frame_q, frame_d;
    logic [15:0]    value_q, value_d;
    logic           fv_q, fv_d;
    logic           seg_err_q, seg_err_d;
    logic           seq_err_q, seq_err_d;
    logic           flagged_q, flagged_d;
    logic [IW-1:0]  idle_q, idle_d;
    logic           active_q, active_d;

    logic           seq_hit, flag_set;
    logic [CW-1:0]  cnt_nx;
    logic [4:0]     dec;
    logic [3:0]     cur_mask;
    logic           others_low;

    assign cur_mask   = 4'b0001 << cur_q;
    assign others_low = (low & ~cur_mask) != 4'd0;
    assign dec        = seg_decode(seg_s);

    always_comb begin
        state_d    = state_q;
        expect_d   = expect_q;
        cur_d      = cur_q;
        cnt_d      = cnt_q;
        seg_prev_d = seg_prev_q;
        frame_d    = frame_q;
        value_d    = value_q;
        fv_d       = 1'b0;
        seg_err_d  = 1'b0;
        seq_hit    = 1'b0;
        flag_set   = 1'b0;
        cnt_nx     = '0;

        case (state_q)
            S_IDLE: begin
                // flagged_q keeps one offending strobe from re-reporting every cycle.
                if (any_low && !flagged_q) begin
                    if (!one_low) begin
                        seq_hit  = 1'b1;
                        flag_set = 1'b1;
                    end else begin
                        if (low_idx != expect_q) begin
                            seq_hit  = 1'b1;
                            expect_d = 2'd3;
                        end
                        if (low_idx == expect_q || low_idx == 2'd3) begin
                            state_d    = S_SETTLE;
                            cur_d      = low_idx;
                            cnt_d      = '0;
                            seg_prev_d = seg_s;
                        end else begin
                            flag_set = 1'b1;
                        end
                    end
                end
            end
            S_SETTLE: begin
                if (others_low) begin
                    seq_hit  = 1'b1;
                    flag_set = 1'b1;
                    state_d  = S_IDLE;
                end else if (!any_low) begin
                    state_d = S_IDLE;
                end else begin
                    // The cycle a change is seen counts as the first stable one.
                    cnt_nx     = (seg_s != seg_prev_q) ? '0 :
                                 (cnt_q == CNT_MAX)    ? cnt_q : cnt_q + CW'(1);
                    cnt_d      = cnt_nx;
                    seg_prev_d = seg_s;
                    if (cnt_nx >= SETTLE_LAST) state_d = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                state_d = S_WAIT_OFF;
                if (!dec[4]) begin
                    seg_err_d = 1'b1;
                    expect_d  = 2'd3;
                end else if (expect_q == 2'd0) begin
                    value_d  = {frame_q[15:4], dec[3:0]};
                    fv_d     = 1'b1;
                    expect_d = 2'd3;
                end else begin
                    frame_d[{expect_q, 2'b00} +: 4] = dec[3:0];
                    expect_d = expect_q - 2'd1;
                end
            end
            S_WAIT_OFF: begin
                if (!any_low) begin
                    state_d = S_IDLE;
                end else if (others_low && !flagged_q) begin
                    seq_hit  = 1'b1;
                    flag_set = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        seq_err_d = seq_hit;
        if (flag_set)      flagged_d = 1'b1;
        else if (!any_low) flagged_d = 1'b0;
        else               flagged_d = flagged_q;

        // Idle counter saturates at TIMEOUT-1; reaching it with all anodes dark drops active.
        idle_d   = any_low ? '0 : ((idle_q == IDLE_MAX) ? idle_q : idle_q + IW'(1));
        active_d = any_low ? 1'b1 : ((idle_q == IDLE_MAX) ? 1'b0 : active_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            expect_q   <= 2'd3;
            cur_q      <= 2'd0;
            cnt_q      <= '0;
            seg_prev_q <= '1;
            frame_q    <= '0;
            value_q    <= '0;
            fv_q       <= 1'b0;
            seg_err_q  <= 1'b0;
            seq_err_q  <= 1'b0;
            flagged_q  <= 1'b0;
            idle_q     <= IDLE_MAX;
            active_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            expect_q   <= expect_d;
            cur_q      <= cur_d;
            cnt_q      <= cnt_d;
            seg_prev_q <= seg_prev_d;
            frame_q    <= frame_d;
            value_q    <= value_d;
            fv_q       <= fv_d;
            seg_err_q  <= seg_err_d;
            seq_err_q  <= seq_err_d;
            flagged_q  <= flagged_d;
            idle_q     <= idle_d;
            active_q   <= active_d;
        end
    end

    assign value       = value_q;
    assign frame_valid = fv_q;
    assign seg_err     = seg_err_q;
    assign seq_err     = seq_err_q;
    assign active      = active_q;

endmodule
